// File: rtl/can_rx_fifo.sv
// CAN receive frame buffer: mask/code acceptance filter in front of a DEPTH-entry FWFT FIFO.
// Define CAN_RX_FIFO_TIMESTAMP_EN to timestamp each entry and expose rd_ts.
module can_rx_fifo #(
    parameter  int DEPTH = 4,
    localparam int LVL_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rx_done,
    input  logic [10:0]      rx_id_std,
    input  logic [17:0]      rx_id_ext,
    input  logic             rx_ide,
    input  logic             rx_rtr,
    input  logic [3:0]       rx_dlc,
    input  logic [7:0]       rx_data [0:7],
    input  logic             filt_en,
    input  logic [28:0]      acc_code,
    input  logic [28:0]      acc_mask,
    output logic             rd_valid,
    input  logic             rd_ready,
    output logic [28:0]      rd_id,
    output logic             rd_ide,
    output logic             rd_rtr,
    output logic [3:0]       rd_dlc,
    output logic [63:0]      rd_data,
`ifdef CAN_RX_FIFO_TIMESTAMP_EN
    output logic [15:0]      rd_ts,
`endif
    output logic [LVL_W-1:0] level,
    output logic             rx_accept,
    output logic             overrun,
    output logic [7:0]       overrun_cnt
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [LVL_W-1:0] r_level;
    logic             r_rx_accept;
    logic             r_overrun;
    logic [7:0]       r_overrun_cnt;

    logic [28:0]      r_mem_id   [DEPTH];
    logic             r_mem_ide  [DEPTH];
    logic             r_mem_rtr  [DEPTH];
    logic [3:0]       r_mem_dlc  [DEPTH];
    logic [63:0]      r_mem_data [DEPTH];

    logic [28:0]      w_id29;
    logic             w_accept;
    logic [3:0]       w_nbytes;
    logic [63:0]      w_data;
    logic             w_full;
    logic             w_rd_valid;
    logic             w_pop;
    logic             w_frame_ok;
    logic             w_push;
    logic             w_drop;

    // NOTE: every signal driven in always_comb gets a default first, so no path leaves it unassigned and infers a latch.
    always_comb begin
        w_data   = '0;
        w_id29   = rx_ide ? {rx_id_std, rx_id_ext} : {rx_id_std, 18'b0};
        w_accept = !filt_en || (((w_id29 ^ acc_code) & acc_mask) == 29'b0);
        if (rx_rtr) begin
            w_nbytes = 4'd0;
        end else if (rx_dlc > 4'd8) begin
            w_nbytes = 4'd8;
        end else begin
            w_nbytes = rx_dlc;
        end
        // Bytes beyond the payload length are zeroed so stale bus data never reaches the host.
        for (int i = 0; i < 8; i++) begin
            w_data[i*8 +: 8] = (4'(i) < w_nbytes) ? rx_data[i] : 8'h00;
        end
    end

    assign w_full     = (r_level == LVL_W'(DEPTH));
    assign w_rd_valid = (r_level != '0);
    assign w_pop      = w_rd_valid & rd_ready;
    assign w_frame_ok = rx_done & w_accept;
    // A pop in the same cycle frees the slot the push lands in, so a full FIFO still accepts.
    assign w_push     = w_frame_ok & (!w_full | w_pop);
    assign w_drop     = w_frame_ok & w_full & !w_pop;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_level       <= '0;
            r_rx_accept   <= 1'b0;
            r_overrun     <= 1'b0;
            r_overrun_cnt <= 8'd0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + LVL_W'(1);
                2'b01:   r_level <= r_level - LVL_W'(1);
                default: r_level <= r_level;
            endcase
            r_rx_accept <= w_push;
            r_overrun   <= w_drop;
            if (w_drop && (r_overrun_cnt != 8'hFF)) begin
                r_overrun_cnt <= r_overrun_cnt + 8'd1;
            end
        end
    end

    // NOTE: the frame storage has no reset; the pointers and level alone define which entries are live.
    always_ff @(posedge clk) begin
        if (w_push && !rst) begin
            r_mem_id[r_wr_ptr]   <= w_id29;
            r_mem_ide[r_wr_ptr]  <= rx_ide;
            r_mem_rtr[r_wr_ptr]  <= rx_rtr;
            r_mem_dlc[r_wr_ptr]  <= rx_dlc;
            r_mem_data[r_wr_ptr] <= w_data;
        end
    end

`ifdef CAN_RX_FIFO_TIMESTAMP_EN
    logic [15:0] r_ts_cnt;
    logic [15:0] r_mem_ts [DEPTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ts_cnt <= 16'd0;
        end else begin
            r_ts_cnt <= r_ts_cnt + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push && !rst) begin
            r_mem_ts[r_wr_ptr] <= r_ts_cnt;
        end
    end

    assign rd_ts = w_rd_valid ? r_mem_ts[r_rd_ptr] : 16'd0;
`endif

    // Head fields are gated so an empty FIFO presents all-zero outputs.
    assign rd_valid    = w_rd_valid;
    assign rd_id       = w_rd_valid ? r_mem_id[r_rd_ptr]   : 29'd0;
    assign rd_ide      = w_rd_valid ? r_mem_ide[r_rd_ptr]  : 1'b0;
    assign rd_rtr      = w_rd_valid ? r_mem_rtr[r_rd_ptr]  : 1'b0;
    assign rd_dlc      = w_rd_valid ? r_mem_dlc[r_rd_ptr]  : 4'd0;
    assign rd_data     = w_rd_valid ? r_mem_data[r_rd_ptr] : 64'd0;
    assign level       = r_level;
    assign rx_accept   = r_rx_accept;
    assign overrun     = r_overrun;
    assign overrun_cnt = r_overrun_cnt;

endmodule
